// File: rtl/psum_post_stage_if.sv
// Beat bus between the PE engine, the psum post stage and OFM writeback.
// The slave modport is the post stage's view of the bus; master is the environment's.
interface psum_post_stage_if #(
  parameter int unsigned W_SIZE    = 9,
  parameter int unsigned W_CHANNEL = 9,
  parameter int unsigned Tout      = 4,
  parameter int unsigned W_PSUM    = 32,
  parameter int unsigned OFM_DW    = 8
);
  logic [Tout*W_PSUM-1:0] pe_data;
  logic                   pe_vld;
  logic [W_SIZE-1:0]      pe_row;
  logic [W_SIZE-1:0]      pe_col;
  logic [W_CHANNEL-1:0]   pe_chn;
  logic [W_CHANNEL-1:0]   pe_chn_out;
  logic                   pe_is_first_chn;
  logic                   pe_is_last_chn;

  logic [Tout*OFM_DW-1:0] o_data;
  logic                   o_vld;
  logic [W_SIZE-1:0]      o_row;
  logic [W_SIZE-1:0]      o_col;
  logic [W_CHANNEL-1:0]   o_chn_out;

  modport master (
    output pe_data, pe_vld, pe_row, pe_col, pe_chn, pe_chn_out, pe_is_first_chn, pe_is_last_chn,
    input  o_data, o_vld, o_row, o_col, o_chn_out
  );

  modport slave (
    input  pe_data, pe_vld, pe_row, pe_col, pe_chn, pe_chn_out, pe_is_first_chn, pe_is_last_chn,
    output o_data, o_vld, o_row, o_col, o_chn_out
  );
endinterface

// File: rtl/psum_post_stage.sv
// Accumulates PE partial sums across input-channel tiles, then applies bias, leaky ReLU
// and rounding requantisation on the last tile. Fixed 4-cycle latency, no backpressure.
module psum_post_stage #(
  parameter int unsigned W_SIZE    = 9,
  parameter int unsigned W_CHANNEL = 9,
  parameter int unsigned Tout      = 4,
  parameter int unsigned W_PSUM    = 32,
  parameter int unsigned OFM_DW    = 8,
  parameter int unsigned W_BIAS    = 16,
  parameter int unsigned W_SHIFT   = 5,
  parameter int unsigned PSUM_AW   = 12
) (
  input  logic                   clk,
  input  logic                   rstn,
  psum_post_stage_if.slave       bus,
  input  logic [W_SIZE-1:0]      q_width,
  input  logic                   q_leaky_en,
  input  logic [W_SHIFT-1:0]     q_shift,
  input  logic [Tout*W_BIAS-1:0] bias_flat,
  output logic [15:0]            o_sat_cnt,
  output logic                   o_busy
);
  localparam int unsigned Dw = Tout * W_PSUM;
  localparam int unsigned Vw = W_PSUM + 1;  // bias add cannot wrap
  localparam int unsigned Rw = W_PSUM + 2;  // rounding add cannot wrap
  localparam int unsigned Cw = $clog2(Tout + 1);
  localparam int          OMax = (1 << (OFM_DW - 1)) - 1;
  localparam int          OMin = -(1 << (OFM_DW - 1));

  typedef struct packed {
    logic [W_SIZE-1:0]    row;
    logic [W_SIZE-1:0]    col;
    logic [W_CHANNEL-1:0] chn_out;
  } tag_t;

  logic [Dw-1:0]      mem [2**PSUM_AW];
  logic [PSUM_AW-1:0] addr0;
  logic [Dw-1:0]      rd_d, rd_q;
  logic               wr_en;

  logic                   s1_vld_d, s1_vld_q, s1_first_d, s1_first_q, s1_last_d, s1_last_q;
  logic [Dw-1:0]          s1_data_d, s1_data_q;
  logic [PSUM_AW-1:0]     s1_addr_d, s1_addr_q;
  tag_t                   s1_tag_d, s1_tag_q;
  logic                   s2_vld_d, s2_vld_q, s2_last_d, s2_last_q;
  logic [Dw-1:0]          s2_sum_d, s2_sum_q;
  logic [PSUM_AW-1:0]     s2_addr_d, s2_addr_q;
  tag_t                   s2_tag_d, s2_tag_q;
  logic                   s3_vld_d, s3_vld_q;
  logic [Tout*Vw-1:0]     s3_v_d, s3_v_q;
  tag_t                   s3_tag_d, s3_tag_q;
  logic                   o_vld_d, o_vld_q;
  logic [Tout*OFM_DW-1:0] o_data_d, o_data_q;
  tag_t                   o_tag_d, o_tag_q;
  logic [15:0]            sat_d, sat_q;

  logic [Dw-1:0]          base;
  logic signed [Vw-1:0]   v_lane [Tout];
  logic signed [Rw-1:0]   x_lane [Tout];
  logic signed [Rw-1:0]   r_lane [Tout];
  logic [Cw-1:0]          clip_cnt;
  logic [16:0]            sat_sum;

  // Modular arithmetic in PSUM_AW bits equals truncating the full-width address.
  assign addr0 = PSUM_AW'(bus.pe_row) * PSUM_AW'(q_width) + PSUM_AW'(bus.pe_col);
  assign wr_en = s2_vld_q & ~s2_last_q;

  // Write-first read: a beat two behind the S2 writer still sees the fresh value.
  always_comb begin
    rd_d = rd_q;
    if (bus.pe_vld) begin
      rd_d = (wr_en && (s2_addr_q == addr0)) ? s2_sum_q : mem[addr0];
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) mem[s2_addr_q] <= s2_sum_q;
    rd_q <= rd_d;
  end

  always_comb begin
    // S0: capture beat
    s1_vld_d   = bus.pe_vld;
    s1_first_d = bus.pe_is_first_chn;
    s1_last_d  = bus.pe_is_last_chn;
    s1_data_d  = bus.pe_data;
    s1_addr_d  = addr0;
    s1_tag_d   = '{row: bus.pe_row, col: bus.pe_col, chn_out: bus.pe_chn_out};

    // S1: accumulate, forwarding the S2 write for back-to-back beats on one address
    if (s1_first_q) begin
      base = '0;
    end else if (wr_en && (s2_addr_q == s1_addr_q)) begin
      base = s2_sum_q;
    end else begin
      base = rd_q;
    end
    for (int i = 0; i < Tout; i++) begin
      s2_sum_d[i*W_PSUM +: W_PSUM] = base[i*W_PSUM +: W_PSUM] + s1_data_q[i*W_PSUM +: W_PSUM];
    end
    s2_vld_d  = s1_vld_q;
    s2_last_d = s1_last_q;
    s2_addr_d = s1_addr_q;
    s2_tag_d  = s1_tag_q;

    // S2: bias and leaky ReLU on the last tile
    for (int i = 0; i < Tout; i++) begin
      v_lane[i] = Vw'($signed(s2_sum_q[i*W_PSUM +: W_PSUM]))
                + Vw'($signed(bias_flat[i*W_BIAS +: W_BIAS]));
      if (q_leaky_en && v_lane[i][Vw-1]) v_lane[i] = v_lane[i] >>> 3;
      s3_v_d[i*Vw +: Vw] = v_lane[i];
    end
    s3_vld_d = s2_vld_q & s2_last_q;
    s3_tag_d = s2_tag_q;

    // S3: round-half-up requant and saturation
    clip_cnt = '0;
    o_data_d = o_data_q;
    for (int i = 0; i < Tout; i++) begin
      x_lane[i] = Rw'($signed(s3_v_q[i*Vw +: Vw]));
      if (q_shift != '0) x_lane[i] = x_lane[i] + (Rw'(1) << (q_shift - 1'b1));
      r_lane[i] = x_lane[i] >>> q_shift;
      if (s3_vld_q) begin
        if (r_lane[i] > Rw'(OMax)) begin
          o_data_d[i*OFM_DW +: OFM_DW] = OFM_DW'(OMax);
          clip_cnt = clip_cnt + Cw'(1);
        end else if (r_lane[i] < Rw'(OMin)) begin
          o_data_d[i*OFM_DW +: OFM_DW] = OFM_DW'(OMin);
          clip_cnt = clip_cnt + Cw'(1);
        end else begin
          o_data_d[i*OFM_DW +: OFM_DW] = OFM_DW'(r_lane[i]);
        end
      end
    end
    sat_sum = {1'b0, sat_q} + 17'(clip_cnt);
    sat_d   = sat_sum[16] ? 16'hFFFF : sat_sum[15:0];
    o_vld_d = s3_vld_q;
    o_tag_d = s3_vld_q ? s3_tag_q : o_tag_q;
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      s1_vld_q   <= 1'b0;
      s1_first_q <= 1'b0;
      s1_last_q  <= 1'b0;
      s1_data_q  <= '0;
      s1_addr_q  <= '0;
      s1_tag_q   <= '0;
      s2_vld_q   <= 1'b0;
      s2_last_q  <= 1'b0;
      s2_sum_q   <= '0;
      s2_addr_q  <= '0;
      s2_tag_q   <= '0;
      s3_vld_q   <= 1'b0;
      s3_v_q     <= '0;
      s3_tag_q   <= '0;
      o_vld_q    <= 1'b0;
      o_data_q   <= '0;
      o_tag_q    <= '0;
      sat_q      <= '0;
    end else begin
      s1_vld_q   <= s1_vld_d;
      s1_first_q <= s1_first_d;
      s1_last_q  <= s1_last_d;
      s1_data_q  <= s1_data_d;
      s1_addr_q  <= s1_addr_d;
      s1_tag_q   <= s1_tag_d;
      s2_vld_q   <= s2_vld_d;
      s2_last_q  <= s2_last_d;
      s2_sum_q   <= s2_sum_d;
      s2_addr_q  <= s2_addr_d;
      s2_tag_q   <= s2_tag_d;
      s3_vld_q   <= s3_vld_d;
      s3_v_q     <= s3_v_d;
      s3_tag_q   <= s3_tag_d;
      o_vld_q    <= o_vld_d;
      o_data_q   <= o_data_d;
      o_tag_q    <= o_tag_d;
      sat_q      <= sat_d;
    end
  end

  assign bus.o_vld     = o_vld_q;
  assign bus.o_data    = o_data_q;
  assign bus.o_row     = o_tag_q.row;
  assign bus.o_col     = o_tag_q.col;
  assign bus.o_chn_out = o_tag_q.chn_out;
  assign o_sat_cnt     = sat_q;
  assign o_busy        = s1_vld_q | s2_vld_q | s3_vld_q | o_vld_q;
endmodule

// File: tb/tb_psum_post_stage.sv
// Directed bench for psum_post_stage: hand-computed vectors checked with immediate assertions.
module tb_psum_post_stage;
  localparam int unsigned W_SIZE    = 9;
  localparam int unsigned W_CHANNEL = 9;
  localparam int unsigned Tout      = 4;
  localparam int unsigned W_PSUM    = 32;
  localparam int unsigned OFM_DW    = 8;
  localparam int unsigned W_BIAS    = 16;
  localparam int unsigned W_SHIFT   = 5;
  localparam int unsigned PSUM_AW   = 12;

  logic                   clk = 1'b0;
  logic                   rstn;
  logic [W_SIZE-1:0]      q_width;
  logic                   q_leaky_en;
  logic [W_SHIFT-1:0]     q_shift;
  logic [Tout*W_BIAS-1:0] bias_flat;
  logic [15:0]            o_sat_cnt;
  logic                   o_busy;
  int                     n_tests = 0;
  int                     n_fail  = 0;
  logic [W_CHANNEL-1:0]   cur_chn_out = '0;

  psum_post_stage_if #(
    .W_SIZE(W_SIZE), .W_CHANNEL(W_CHANNEL), .Tout(Tout), .W_PSUM(W_PSUM), .OFM_DW(OFM_DW)
  ) bus ();

  psum_post_stage #(
    .W_SIZE(W_SIZE), .W_CHANNEL(W_CHANNEL), .Tout(Tout), .W_PSUM(W_PSUM), .OFM_DW(OFM_DW),
    .W_BIAS(W_BIAS), .W_SHIFT(W_SHIFT), .PSUM_AW(PSUM_AW)
  ) dut (
    .clk       (clk),
    .rstn      (rstn),
    .bus       (bus),
    .q_width   (q_width),
    .q_leaky_en(q_leaky_en),
    .q_shift   (q_shift),
    .bias_flat (bias_flat),
    .o_sat_cnt (o_sat_cnt),
    .o_busy    (o_busy)
  );

  always #5 clk = ~clk;

  function automatic logic [127:0] pk32(input int a, input int b, input int c, input int d);
    return {d, c, b, a};
  endfunction

  function automatic logic [31:0] pk8(input int a, input int b, input int c, input int d);
    return {d[7:0], c[7:0], b[7:0], a[7:0]};
  endfunction

  function automatic logic [63:0] pkb(input int a, input int b, input int c, input int d);
    return {d[15:0], c[15:0], b[15:0], a[15:0]};
  endfunction

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic beat(input int row, input int col, input bit first, input bit last,
                      input logic [127:0] data);
    bus.pe_vld          = 1'b1;
    bus.pe_row          = W_SIZE'(row);
    bus.pe_col          = W_SIZE'(col);
    bus.pe_chn          = '0;
    bus.pe_chn_out      = cur_chn_out;
    bus.pe_is_first_chn = first;
    bus.pe_is_last_chn  = last;
    bus.pe_data         = data;
  endtask

  task automatic idle();
    bus.pe_vld = 1'b0;
  endtask

  initial begin
    rstn       = 1'b0;
    q_width    = 9'd4;
    q_leaky_en = 1'b0;
    q_shift    = '0;
    bias_flat  = '0;
    bus.pe_data = '0;
    bus.pe_row = '0;
    bus.pe_col = '0;
    bus.pe_chn = '0;
    bus.pe_chn_out = '0;
    bus.pe_is_first_chn = 1'b0;
    bus.pe_is_last_chn = 1'b0;
    idle();
    #1;
    check("reset_vld", bus.o_vld, 0);
    check("reset_data", bus.o_data, 0);
    check("reset_sat", o_sat_cnt, 0);
    check("reset_busy", o_busy, 0);
    tick();
    tick();
    rstn = 1'b1;
    tick();

    // Single tile with bias and one clipped lane; latency exactly 4 cycles
    bias_flat   = pkb(0, 5, 0, 0);
    cur_chn_out = 9'd2;
    beat(3, 1, 1, 1, pk32(10, -20, 300, 0));
    tick();
    idle();
    check("t1_lat0", bus.o_vld, 0);
    tick();
    check("t1_lat1", bus.o_vld, 0);
    tick();
    check("t1_lat2", bus.o_vld, 0);
    tick();
    check("t1_vld", bus.o_vld, 1);
    check("t1_data", bus.o_data, pk8(10, -15, 127, 0));
    check("t1_tag", {bus.o_row, bus.o_col, bus.o_chn_out}, {9'd3, 9'd1, 9'd2});
    check("t1_sat", o_sat_cnt, 1);
    tick();
    check("t1_vld_drop", bus.o_vld, 0);

    // Three tiles at (0,2) interleaved with two tiles at (1,2); shift 2
    bias_flat   = '0;
    q_shift     = 5'd2;
    cur_chn_out = 9'd0;
    beat(0, 2, 1, 0, pk32(100, 0, 0, 0));
    tick();
    beat(1, 2, 1, 0, pk32(1000, 0, 0, 0));
    tick();
    beat(0, 2, 0, 0, pk32(200, 0, 0, 0));
    tick();
    beat(0, 2, 0, 1, pk32(-50, 0, 0, 0));
    tick();
    check("t2_nowrite_out0", bus.o_vld, 0);
    beat(1, 2, 0, 1, pk32(4, 0, 0, 0));
    tick();
    idle();
    check("t2_nowrite_out1", bus.o_vld, 0);
    tick();
    check("t2_nowrite_out2", bus.o_vld, 0);
    tick();
    check("t2_a_vld", bus.o_vld, 1);
    check("t2_a_data", bus.o_data, pk8(63, 0, 0, 0));
    check("t2_a_tag", {bus.o_row, bus.o_col}, {9'd0, 9'd2});
    tick();
    check("t2_b_vld", bus.o_vld, 1);
    check("t2_b_data", bus.o_data, pk8(127, 0, 0, 0));
    check("t2_b_tag", {bus.o_row, bus.o_col}, {9'd1, 9'd2});
    check("t2_sat", o_sat_cnt, 2);
    tick();
    check("t2_end", bus.o_vld, 0);

    // Leaky ReLU with floor division, shift 0
    q_shift    = '0;
    q_leaky_en = 1'b1;
    beat(2, 0, 1, 1, pk32(-80, -81, 80, -1));
    tick();
    idle();
    tick();
    tick();
    tick();
    check("t3_vld", bus.o_vld, 1);
    check("t3_leaky", bus.o_data, pk8(-10, -11, 80, -1));
    q_leaky_en = 1'b0;

    // Rounding with shift 3, including both saturation rails
    q_shift = 5'd3;
    beat(2, 1, 1, 1, pk32(-12, -13, 1023, -1030));
    tick();
    idle();
    tick();
    tick();
    tick();
    check("t3b_round", bus.o_data, pk8(-1, -2, 127, -128));
    check("t3b_sat", o_sat_cnt, 4);

    // RAW forwarding: q_width 1 maps (2,0),(1,1),(0,2) onto address 2
    q_shift = '0;
    q_width = 9'd1;
    beat(2, 0, 1, 0, pk32(1, -1, 0, 0));
    tick();
    beat(1, 1, 0, 0, pk32(2, -2, 0, 0));
    tick();
    beat(0, 2, 0, 1, pk32(3, -3, 0, 0));
    tick();
    idle();
    tick();
    tick();
    check("t4_pre", bus.o_vld, 0);
    tick();
    check("t4_vld", bus.o_vld, 1);
    check("t4_fwd", bus.o_data, pk8(6, -6, 0, 0));
    check("t4_tag", {bus.o_row, bus.o_col}, {9'd0, 9'd2});

    // Throughput: 16 back-to-back single-tile beats
    q_width     = 9'd4;
    cur_chn_out = 9'd5;
    for (int t = 0; t < 19; t++) begin
      if (t < 16) beat(0, t, 1, 1, pk32(t, -t, 2 * t, 0));
      else idle();
      tick();
      if (t >= 3) begin
        check("t5_vld", bus.o_vld, 1);
        check("t5_col", {bus.o_col, bus.o_chn_out}, {9'(t - 3), 9'd5});
        check("t5_data", bus.o_data, pk8(t - 3, 3 - t, 2 * (t - 3), 0));
      end
    end
    tick();
    check("t5_end", bus.o_vld, 0);
    check("t5_sat", o_sat_cnt, 4);

    // Asynchronous reset with three beats in flight
    for (int t = 0; t < 3; t++) begin
      beat(1, t, 1, 1, pk32(1000, 1000, 1000, 1000));
      tick();
    end
    idle();
    check("t6_busy", o_busy, 1);
    #2;
    rstn = 1'b0;
    #1;
    check("t6_rst_vld", bus.o_vld, 0);
    check("t6_rst_sat", o_sat_cnt, 0);
    check("t6_rst_busy", o_busy, 0);
    #2;
    rstn = 1'b1;
    tick();
    tick();
    tick();
    tick();
    check("t6_dropped", bus.o_vld, 0);
    beat(4, 4, 1, 1, pk32(-128, 127, -5, 7));
    tick();
    idle();
    tick();
    tick();
    tick();
    check("t6_vld", bus.o_vld, 1);
    check("t6_data", bus.o_data, pk8(-128, 127, -5, 7));
    check("t6_sat", o_sat_cnt, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/psum_post_stage.md
Name: psum_post_stage

Overview:
- Consumes per-position, per-input-channel-tile partial sums from the PE engine: Tout lanes of W_PSUM bits plus row/col/chn/chn_out tags and first/last-channel flags.
- Accumulates partial sums across input-channel tiles in an internal psum buffer.
- On the last channel tile, applies per-lane bias, optional leaky ReLU and requantisation to OFM_DW-bit signed values.
- Output is a valid-tagged stream for the OFM writeback stage.

Parameters:
- W_SIZE, 9, row/col index width
- W_CHANNEL, 9, channel index width
- Tout, 4, output-channel lanes per beat
- W_PSUM, 32, signed partial-sum width per lane
- OFM_DW, 8, signed output width per lane
- W_BIAS, 16, signed bias width per lane
- W_SHIFT, 5, requant shift width
- PSUM_AW, 12, psum buffer address width (depth 2^PSUM_AW words of Tout*W_PSUM bits)

Ports:
- clk  in  1  clock
- rstn  in  1  async active-low reset
- pe_data  in  Tout*W_PSUM  partial sums; lane i at bits [i*W_PSUM +: W_PSUM]
- pe_vld  in  1  beat valid
- pe_row, pe_col  in  W_SIZE  position tags
- pe_chn  in  W_CHANNEL  input-channel tile index
- pe_chn_out  in  W_CHANNEL  output-channel group index
- pe_is_first_chn  in  1  first input tile for this position
- pe_is_last_chn  in  1  last input tile for this position
- q_width  in  W_SIZE  tile width, used for addressing
- q_leaky_en  in  1  enable leaky ReLU
- q_shift  in  W_SHIFT  requant right-shift amount
- bias_flat  in  Tout*W_BIAS  per-lane bias; stable while a chn_out group is processed
- o_data  out  Tout*OFM_DW  quantised outputs
- o_vld  out  1  output valid
- o_row, o_col  out  W_SIZE  position of o_data
- o_chn_out  out  W_CHANNEL  output group of o_data
- o_sat_cnt  out  16  saturating count of lanes clipped in requant
- o_busy  out  1  any pipeline stage holds a valid beat

Behaviour:
- Reset: all outputs 0, pipeline valids 0, o_sat_cnt 0. Buffer contents are not reset.
- No backpressure: one beat per cycle accepted unconditionally. Downstream must always sink o_vld.
- Address: addr = pe_row*q_width + pe_col, truncated to PSUM_AW bits.
- S0 (input cycle): register the beat and issue a synchronous buffer read at addr.
- S1: base = 0 if first_chn, else the buffer read data.
  - Forwarding: if S2 is writing the same addr in this cycle, take base from S2's write data (RAW hazard when q_width==1).
  - sum = base + pe_data per lane, modulo 2^W_PSUM (no saturation).
- S2:
  - If !last_chn: write sum to buffer at addr. No output.
  - If last_chn: no write. v = sum + sign-extended bias. If q_leaky_en and v<0, v = v>>>3 (arithmetic, floor).
- S3, requant:
  - If q_shift>0, r = (v + (1<<(q_shift-1)))>>>q_shift; otherwise r = v.
  - Saturate r to [-2^(OFM_DW-1), 2^(OFM_DW-1)-1].
  - Each clipped lane increments o_sat_cnt, which sticks at 0xFFFF.
- Output: o_vld and tags are registered. Latency is exactly 4 cycles from pe_vld (last_chn) to o_vld. Output order equals input order.
- first_chn and last_chn both 1 (single tile): base = 0, output produced, no write.
- Beats without pe_vld produce nothing and perform no write.
- Async reset mid-operation: in-flight beats are dropped, o_vld deasserts immediately.

Test Plan:
- Single tile: first=last=1, lanes {10,-20,300,0}, bias {0,5,0,0}, shift 0, leaky off -> 4 cycles later o_data lanes {10,-15,127,0}, o_sat_cnt=1.
- Three tiles at (row0,col2), q_width 4, lane0 psums 100, 200, -50; shift 2 -> lane0 out (250+2)>>>2=63. Buffer reads occur at addr 2.
- Leaky: last-tile sum -80, bias 0, leaky on, shift 0 -> -10. Sum -81 -> -11 (floor).
- RAW forwarding: q_width=1, back-to-back beats on same addr, tiles 0/1/2 with values 1/2/3, last on 3rd beat -> output 6, not 3 or 4.
- Throughput: 16 consecutive last-tile beats, cols 0..15 -> 16 consecutive o_vld cycles, cols in order, latency 4.
- Reset: assert rstn low while 3 beats are in flight -> o_vld=0, o_sat_cnt=0. After release, a new single-tile beat outputs correctly.
